// File: rtl/keccak_squeeze_ctrl.sv
// keccak_squeeze_ctrl: Keccak squeeze-phase sequencer.
// Owns the byte-offset counter that feeds the output window unit.
// Streams 256-bit windows on a valid/ready master port.
// Requests a permutation when the rate block is drained.
// Ends SHA3 digests on win_last_i and SHAKE streams on xof_stop_i.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   squeeze_start_i       begin squeezing (ignored while busy_o)
//   xof_stop_i            pulse: terminate a SHAKE stream
//   keccak_mode_i         0/1 SHA3-256/512, 2/3 SHAKE128/256
//   bytes_squeezed_o      byte offset into the rate block
//   bytes_squeezed_next_i offset of the following beat
//   squeeze_perm_needed_i current beat drains the rate block
//   win_data_i/keep/last  window beat from the window unit
//   perm_start_o          one-cycle permutation request
//   perm_done_i           one-cycle permutation complete
//   m_t*                  stream master port
//   busy_o, done_o        not idle / squeeze finished pulse
module keccak_squeeze_ctrl #(
   parameter int DWIDTH         = 256,
   parameter int CNT_W          = 8,
   parameter int MODE_SEL_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      squeeze_start_i,
   input  logic                      xof_stop_i,
   input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
   output logic [CNT_W-1:0]          bytes_squeezed_o,
   input  logic [CNT_W-1:0]          bytes_squeezed_next_i,
   input  logic                      squeeze_perm_needed_i,
   input  logic [DWIDTH-1:0]         win_data_i,
   input  logic [DWIDTH/8-1:0]       win_keep_i,
   input  logic                      win_last_i,
   output logic                      perm_start_o,
   input  logic                      perm_done_i,
   output logic [DWIDTH-1:0]         m_tdata_o,
   output logic [DWIDTH/8-1:0]       m_tkeep_o,
   output logic                      m_tvalid_o,
   output logic                      m_tlast_o,
   input  logic                      m_tready_i,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE128 =
      MODE_SEL_WIDTH'(2);
   localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE256 =
      MODE_SEL_WIDTH'(3);

   typedef enum logic [1:0] {
      IDLE,
      SQUEEZE,
      PERMUTE
   } state_t;

   state_t                    state;
   state_t                    state_n;
   logic [CNT_W-1:0]          cnt;
   logic [CNT_W-1:0]          cnt_n;
   logic [MODE_SEL_WIDTH-1:0] mode_q;
   logic [MODE_SEL_WIDTH-1:0] mode_n;
   logic                      stop_q;
   logic                      stop_n;
   logic                      perm_q;
   logic                      perm_n;
   logic                      done_q;
   logic                      done_n;
   logic                      xof;
   logic                      stop_now;

   // Only SHAKE streams honour an external stop.
   assign xof = (mode_q == MODE_SHAKE128) ||
                (mode_q == MODE_SHAKE256);
   assign stop_now = xof && xof_stop_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         mode_q <= '0;
         stop_q <= 1'b0;
         perm_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mode_q <= mode_n;
         stop_q <= stop_n;
         perm_q <= perm_n;
         done_q <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      mode_n  = mode_q;
      stop_n  = stop_q;
      perm_n  = 1'b0;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (squeeze_start_i) begin
               mode_n  = keccak_mode_i;
               cnt_n   = '0;
               stop_n  = 1'b0;
               state_n = SQUEEZE;
            end
         end
         SQUEEZE: begin
            // Nothing advances until the beat is accepted,
            // so a stalled beat stays stable.
            if (m_tready_i) begin
               if (win_last_i) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  stop_n  = 1'b0;
               end else if (stop_q || stop_now) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  stop_n  = 1'b0;
               end else if (squeeze_perm_needed_i) begin
                  cnt_n   = '0;
                  perm_n  = 1'b1;
                  state_n = PERMUTE;
               end else begin
                  cnt_n = bytes_squeezed_next_i;
               end
            end else if (stop_now) begin
               stop_n = 1'b1;
            end
         end
         PERMUTE: begin
            if (stop_now) begin
               stop_n = 1'b1;
            end
            // A running permutation is always allowed to finish;
            // a pending stop only takes effect at its completion.
            if (perm_done_i) begin
               cnt_n = '0;
               if (stop_q || stop_now) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  stop_n  = 1'b0;
               end else begin
                  state_n = SQUEEZE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign m_tvalid_o       = (state == SQUEEZE);
   assign m_tdata_o        = m_tvalid_o ? win_data_i : '0;
   assign m_tkeep_o        = m_tvalid_o ? win_keep_i : '0;
   assign m_tlast_o        = m_tvalid_o && win_last_i;
   assign bytes_squeezed_o = cnt;
   assign perm_start_o     = perm_q;
   assign done_o           = done_q;
   assign busy_o           = (state != IDLE);

endmodule

// File: doc/keccak_squeeze_ctrl.md
Name: keccak_squeeze_ctrl

Overview:
Sequences the Keccak squeeze phase. It owns the byte-offset counter that drives the output-window datapath and presents each 256-bit window on an AXI-Stream-style master port with valid/ready handshaking. When the rate block is drained it requests a permutation. It ends SHA3-256/512 on the fixed digest length and SHAKE128/256 on an external stop. It sits between the absorb/permutation FSM and the output window unit.

Parameters:
DWIDTH, 256, output bus width in bits (MAX_OUTPUT_DWIDTH); one beat carries DWIDTH/8 = 32 bytes
CNT_W, BYTE_ABSORB_WIDTH, width of the byte-offset counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
squeeze_start_i  input  1  state array holds the final absorbed, permuted state; begin squeezing
xof_stop_i  input  1  pulse: terminate a SHAKE stream
keccak_mode_i  input  MODE_SEL_WIDTH  mode; sampled on start, held internally
bytes_squeezed_o  output  CNT_W  current byte offset to the window unit
bytes_squeezed_next_i  input  CNT_W  window unit's offset + 32
squeeze_perm_needed_i  input  1  window unit: the current beat drains the rate
win_data_i  input  DWIDTH  window data
win_keep_i  input  DWIDTH/8  window byte enables
win_last_i  input  1  window unit: fixed-length digest ends on this beat
perm_start_o  output  1  one-cycle request to permute the state
perm_done_i  input  1  one-cycle pulse: permutation complete, state updated
m_tdata_o  output  DWIDTH  stream data
m_tkeep_o  output  DWIDTH/8  stream byte enables
m_tvalid_o  output  1  stream valid
m_tlast_o  output  1  final beat of a fixed-length digest
m_tready_i  input  1  downstream ready
busy_o  output  1  not IDLE
done_o  output  1  one-cycle pulse when the squeeze ends

Behaviour:
- Reset: state=IDLE; counter=0; stop_pending=0; every output 0. A reset mid-operation drops the stream immediately and issues no perm_start_o. Cleanup of an in-flight permutation is the permutation unit's job.
- States: IDLE, SQUEEZE, PERMUTE.
- IDLE: on squeeze_start_i, latch the mode, set counter=0, clear stop_pending, and go to SQUEEZE next cycle. While busy_o=1, squeeze_start_i is ignored.
- SQUEEZE: m_tvalid_o=1. m_tdata_o/m_tkeep_o/m_tlast_o pass through combinationally from win_data_i/win_keep_i/win_last_i.
  - The counter is held and the state array is not permuted until handshake (tvalid&tready). The beat is therefore stable while stalled.
- On a handshake, exactly one action is taken, in this priority order:
  1. win_last_i=1: go to IDLE, pulse done_o.
  2. stop_pending=1 or xof_stop_i=1: go to IDLE, pulse done_o. The accepted beat is the final one. XOF streams never assert tlast.
  3. squeeze_perm_needed_i=1: counter<=0, pulse perm_start_o (the cycle after the handshake, registered), go to PERMUTE.
  4. Otherwise: counter<=bytes_squeezed_next_i.
- xof_stop_i arriving with no handshake in the same cycle sets stop_pending. The beat currently presented still completes; no further beat is started. The termination takes effect at that beat's handshake (rule 2).
- PERMUTE: m_tvalid_o=0. Wait for perm_done_i, then go to SQUEEZE next cycle with counter=0.
  - If stop_pending is set (stop arrived before or during PERMUTE), go to IDLE on perm_done_i and pulse done_o. No beat is emitted; a running permutation is never aborted.
- xof_stop_i in IDLE is ignored. xof_stop_i in SHA3 modes is ignored (win_last_i governs).
- perm_done_i outside PERMUTE is ignored.
- First-beat latency: squeeze_start_i at cycle N gives m_tvalid_o=1 at N+1.
- Gap between a rate-draining beat and the first beat of the next block: 1 cycle (perm_start_o) + permutation latency + 1 cycle.
- With tready held high, throughput is 1 beat/cycle within a rate block.

Test Plan:
- SHA3-256, tready=1: start -> 1 beat, bytes_squeezed_o=0, tkeep=0xFFFFFFFF, tlast=1, done_o pulse next cycle, no perm_start_o.
- SHA3-512 with tready toggling 1,0,0,1: 2 beats at offsets 0 and 32. Data/keep stay stable during the stall. tlast only on beat 2.
- SHAKE128 (rate 168 B): beats at offsets 0,32,64,96,128,160. Beat 6 has tkeep=0x000000FF and produces perm_start_o. After perm_done_i, the next beat is at offset 0.
- SHAKE256 (rate 136 B): the beat at offset 128 has tkeep=0xFF and triggers a permutation. Stop asserted during PERMUTE -> after perm_done_i, IDLE + done_o, zero further beats.
- SHAKE128: xof_stop_i while beat 3 is stalled (tready=0) -> beat 3 is accepted on tready, then IDLE, done_o, tlast never 1.
- rst asserted in SQUEEZE and in PERMUTE -> next cycle all outputs 0, busy_o=0. A squeeze_start_i during busy has no effect.
